// File: rtl/panel_capture_pkg.sv
// Shared geometry, lock-state enum and snapshot types for the VGA panel capture block.
package panel_capture_pkg;

  localparam int CELL_PITCH   = 70;
  localparam int CELL_ORIGIN  = 20;
  localparam int CENTRE_OFS   = 30;
  localparam int CURSOR_LINE  = 460;
  localparam int HS_FALL_PIX  = 656;
  localparam int VS_FALL_LINE = 491;
  localparam int COMMIT_LINE  = 480;
  localparam int ROWS         = 6;
  localparam int COLS         = 7;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED
  } lock_state_e;

  typedef logic [5:0][6:0][1:0] panel_t;

  typedef struct packed {
    panel_t     panel;
    logic [6:0] play;
    logic       player;
  } snap_t;

  // Pixel (or line) coordinate of the centre of cell/slot k.
  function automatic logic [9:0] slot_centre(input int k);
    return 10'(CELL_ORIGIN + CENTRE_OFS + CELL_PITCH * k);
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers the VGA inputs, runs the h/v position counters and the sync lock FSM.
module vga_sync_tracker
  import panel_capture_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 527
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        red3,
  input  logic        green3,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        red_s,
  output logic        green_s,
  output logic        vs_fall,
  output logic        locked,
  output logic        sync_error,
  output lock_state_e state,
  output lock_state_e state_next
);

  localparam logic [10:0] H_LAST    = 11'(2 * H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_LOAD   = 11'(2 * HS_FALL_PIX);
  localparam logic [10:0] HS_EXPECT = 11'(2 * HS_FALL_PIX - 1);
  localparam logic [9:0]  VS_LOAD   = 10'(VS_FALL_LINE);
  localparam logic [9:0]  VS_EXPECT = 10'(VS_FALL_LINE - 1);

  logic        hs_q, hs_d, vs_q, vs_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic        red_q, red_d, green_q, green_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  lock_state_e state_q, state_d;
  logic        hs_fall, h_wrap, hs_bad, vs_bad_v, vs_bad_h;

  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;
  assign h_wrap  = (h_cnt_q == H_LAST) && !hs_fall;

  always_comb begin
    hs_d      = hsync;
    vs_d      = vsync;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
    red_d     = red3;
    green_d   = green3;

    h_cnt_d = (h_cnt_q == H_LAST) ? 11'd0 : h_cnt_q + 11'd1;
    if (hs_fall) h_cnt_d = HS_LOAD;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    if (vs_fall) v_cnt_d = VS_LOAD;

    // A sync edge is good only if the free-running counters already predicted it.
    hs_bad   = hs_fall && (h_cnt_q != HS_EXPECT);
    vs_bad_v = vs_fall && (v_cnt_q != VS_EXPECT);
    vs_bad_h = vs_fall && (h_cnt_q != H_LAST);

    state_d    = state_q;
    sync_error = 1'b0;
    case (state_q)
      ST_UNLOCKED: if (vs_fall) state_d = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (hs_bad || vs_bad_v || vs_bad_h) begin
          sync_error = 1'b1;
          state_d    = ST_UNLOCKED;
        end else if (vs_fall) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (hs_bad || vs_bad_v) begin
          sync_error = 1'b1;
          state_d    = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      red_q     <= 1'b0;
      green_q   <= 1'b0;
      h_cnt_q   <= 11'd0;
      v_cnt_q   <= 10'd0;
      state_q   <= ST_UNLOCKED;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      red_q     <= red_d;
      green_q   <= green_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      state_q   <= state_d;
    end
  end

  assign h_cnt      = h_cnt_q;
  assign v_cnt      = v_cnt_q;
  assign red_s      = red_q;
  assign green_s    = green_q;
  assign locked     = (state_q == ST_LOCKED);
  assign state      = state_q;
  assign state_next = state_d;

endmodule

// File: rtl/panel_capture.sv
// VGA receive side: samples cell and cursor centres and commits one snapshot per locked frame.
// Define PANEL_CAPTURE_DEBOUNCE_EN to commit only after two identical consecutive frames.
module panel_capture
  import panel_capture_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 527
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [3:0]           red,
  input  logic [3:0]           green,
  input  logic [3:0]           blue,
  output logic [5:0][6:0][1:0] panel,
  output logic [6:0]           play,
  output logic                 player,
  output logic                 locked,
  output logic                 frame_valid,
  output logic                 sync_error
);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt, px;
  logic        red_s, green_s, vs_fall;
  lock_state_e trk_state, trk_state_next;
  snap_t       shadow_q, shadow_d, snap_q, snap_d;
  logic        full_q, full_d, fv_q, fv_d;
  logic        commit_pt, stay_locked, do_commit;
  logic        unused_colour;

  assign unused_colour = ^{blue, red[2:0], green[2:0]};

  vga_sync_tracker #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .hsync     (hsync),
    .vsync     (vsync),
    .red3      (red[3]),
    .green3    (green[3]),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .red_s     (red_s),
    .green_s   (green_s),
    .vs_fall   (vs_fall),
    .locked    (locked),
    .sync_error(sync_error),
    .state     (trk_state),
    .state_next(trk_state_next)
  );

  assign px = h_cnt[10:1];

  // Screen row i is drawn top-down, but panel row 0 is the bottom of the board.
  always_comb begin
    shadow_d = shadow_q;
    if (h_cnt[0]) begin
      for (logic [2:0] j = 3'd0; j < 3'd7; j++) begin
        if (px == slot_centre(int'(j))) begin
          for (logic [2:0] i = 3'd0; i < 3'd6; i++) begin
            if (v_cnt == slot_centre(int'(i))) shadow_d.panel[3'd5 - i][j] = {red_s, green_s};
          end
          if (v_cnt == 10'(CURSOR_LINE)) begin
            shadow_d.play[j] = red_s ^ green_s;
            if (red_s ^ green_s) shadow_d.player = red_s;
          end
        end
      end
    end
  end

`ifdef PANEL_CAPTURE_DEBOUNCE_EN
  snap_t prev_q, prev_d;
`endif

  // full_q: LOCKED at the last vsync fall and never dropped since.
  always_comb begin
    commit_pt   = (v_cnt == 10'(COMMIT_LINE)) && (h_cnt == 11'd0);
    stay_locked = (trk_state_next == ST_LOCKED);
    full_d      = full_q && stay_locked;
    if (vs_fall) full_d = (trk_state == ST_LOCKED) && stay_locked;
    do_commit   = commit_pt && full_q && stay_locked;
`ifdef PANEL_CAPTURE_DEBOUNCE_EN
    do_commit   = do_commit && (shadow_q == prev_q);
    prev_d      = commit_pt ? shadow_q : prev_q;
`endif
    snap_d      = do_commit ? shadow_q : snap_q;
    fv_d        = do_commit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      snap_q   <= '0;
      full_q   <= 1'b0;
      fv_q     <= 1'b0;
`ifdef PANEL_CAPTURE_DEBOUNCE_EN
      prev_q   <= '0;
`endif
    end else begin
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      full_q   <= full_d;
      fv_q     <= fv_d;
`ifdef PANEL_CAPTURE_DEBOUNCE_EN
      prev_q   <= prev_d;
`endif
    end
  end

  assign panel       = snap_q.panel;
  assign play        = snap_q.play;
  assign player      = snap_q.player;
  assign frame_valid = fv_q;

endmodule
